rv_dmem: RTL and testbench
==========================

Name: rv_dmem

Overview:
Data memory subsystem directly downstream of the pipelined core's MEM stage, consuming the core's o_core_dmem_* bus.
- Provides byte-addressed RAM with RV32I sub-word load/store semantics.
- Provides a small MMIO window: a 64-bit cycle counter, a tohost/halt register and a sticky access-error status register.
- Reads are combinational because the core samples read data in MEM. Writes commit on the rising clock edge.

Parameters:
DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two); RAM spans byte addresses [0, 4*DEPTH_WORDS).
MMIO_BASE, 32'hFFFF_0000, base of the MMIO window; an address is MMIO when a[31:4] == MMIO_BASE[31:4].

Ports:
i_dmem_clk  in  1  clock
i_dmem_rstn  in  1  reset; asynchronous, active-low
i_dmem_a  in  XLEN  byte address
i_dmem_wd  in  XLEN  store data, right-aligned (byte in [7:0], half in [15:0])
i_dmem_we  in  1  store enable
i_dmem_bytectrl  in  3  access type, equal to func3: 000 B, 001 H, 010 W, 100 BU, 101 HU
o_dmem_rd  out  XLEN  load data, combinational, extended per bytectrl
o_dmem_halt  out  1  sticky halt request to the testbench
o_dmem_tohost  out  XLEN  last value written to TOHOST
o_dmem_status  out  2  sticky errors: [0] misaligned, [1] out-of-range or illegal bytectrl

Behaviour:
Reset (async assert, sync release):
- Counter = 0, tohost = 0, halt = 0, status = 0.
- RAM contents are not reset; the bench preloads them via $readmemh.

Alignment:
- H/HU with a[0]=1 is misaligned.
- W with a[1:0]!=0 is misaligned.
- B/BU is always aligned.

Illegal access: bytectrl 011, 110 or 111, or an address that is neither RAM nor MMIO.

Faulting access (misaligned or illegal):
- rd = 0; any write is suppressed.
- The error bit is set on the next edge, but only if i_dmem_we=1 or the address is being read. The core always drives the bus, so errors are flagged only when i_dmem_we=1 or the access is qualified by a load. Decision: only stores set status bits; loads return 0 silently.
- Misaligned takes precedence over illegal (status[0] only).

RAM store (edge):
- Word index = a[log2(4*DEPTH_WORDS)-1:2].
- B writes lane a[1:0]; H writes lanes {a[1],0} and {a[1],1}; W writes all four lanes; untouched lanes are preserved.

RAM load (combinational):
- Select the lane(s) by a[1:0].
- B/H sign-extend; BU/HU zero-extend; W passes through.
- Read-during-write to the same address returns the pre-edge (old) data.

MMIO registers (word accesses only; B/H/BU/HU to MMIO is treated as misaligned):
- +0x0 MTIME_LO, RO: counter[31:0].
- +0x4 MTIME_HI, RO: counter[63:32].
- +0x8 TOHOST, RW: a write latches wd. If wd[0]=1, halt is set and stays set until reset.
- +0xC STATUS, RW1C: reads {30'b0, status}; writing 1 clears the corresponding bit.
- Writes to RO registers are ignored and do not flag an error.

Counter:
- Increments by 1 every cycle while halt=0 and wraps 2^64-1 -> 0.
- Freezes in the cycle after halt rises.
- The HI/LO pair is not read atomically; software rereads HI.

Simultaneous events:
- An error being set in the same cycle as a W1C clear of that bit: set wins.
- A TOHOST write while halt=1 still updates tohost; halt stays 1.
- Reset asserted mid-store: the store is lost; registers reset immediately.

Decomposition:
- Shared config include (rv_configs.v) holds the XLEN, bytectrl encodings, MMIO offsets and the status bit indices.
- One combinational sub-module, rv_dmem_align, handles byte-lane write-mask/data generation and load extraction/extension. It is reusable by a future cache.
- The top level holds the RAM array, MMIO registers, counter and address decode.

Test Plan:
- SW 0x8899AABB at 0x10, then LB/LBU at 0x13 -> rd=0xFFFFFF88 / 0x00000088; LH at 0x10 -> 0xFFFFAABB; LHU at 0x12 -> 0x00008899.
- SB 0x5A at 0x21 over word 0x11223344 -> LW 0x20 = 0x11225A44; SH 0xBEEF at 0x22 -> LW = 0xBEEF5A44.
- SW at 0x6 (misaligned) -> RAM unchanged, status=01. Then SW 0x1 to STATUS -> status=00. A misaligned store in the same cycle as that clear -> status stays 01.
- Read MTIME_LO 10 cycles after reset release -> value 10 (±1 per the sampling edge). Preload counter 0xFFFFFFFF_FFFFFFFF via force -> next cycle MTIME_HI/LO = 0/0.
- SW 0x1 to TOHOST -> halt=1, tohost=1, MTIME frozen across 5 cycles. SW 0x4 -> tohost=4, halt stays 1.
- SW to 0x0001_0000 (unmapped) -> status[1]=1; LW from there -> rd=0. Assert rstn mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rv_dmem_pkg.sv
// rv_dmem_pkg: shared definitions for the data memory subsystem.
//   - XLEN and the load/store access-type encodings (equal to RV32I func3)
//   - MMIO register offsets (word index inside the 16-byte window)
//   - sticky status bit indices
package rv_dmem_pkg;

    localparam int XLEN = 32;

    // Access type encodings, identical to the load/store func3 field.
    localparam logic [2:0] BC_B  = 3'b000;
    localparam logic [2:0] BC_H  = 3'b001;
    localparam logic [2:0] BC_W  = 3'b010;
    localparam logic [2:0] BC_BU = 3'b100;
    localparam logic [2:0] BC_HU = 3'b101;

    // MMIO registers, selected by a[3:2] inside the window.
    typedef enum logic [1:0] {
        MMIO_MTIME_LO = 2'd0,
        MMIO_MTIME_HI = 2'd1,
        MMIO_TOHOST   = 2'd2,
        MMIO_STATUS   = 2'd3
    } mmio_reg_e;

    // Sticky status bits.
    localparam int ST_MISALIGN = 0;
    localparam int ST_ILLEGAL  = 1;

    function automatic logic bc_legal(input logic [2:0] bc);
        return bc inside {BC_B, BC_H, BC_W, BC_BU, BC_HU};
    endfunction

endpackage

// File: rtl/rv_dmem_align.sv
// rv_dmem_align: byte-lane steering for sub-word accesses (purely combinational).
//   i_lane        byte offset a[1:0]
//   i_bytectrl    access type (func3 encoding)
//   i_wd          right-aligned store data
//   i_rword       32-bit word currently held at the addressed location
//   o_wmask       byte-lane write enables for a store
//   o_wdata       store data replicated onto the lanes
//   o_rd          load data extracted from i_rword and sign/zero extended
//   o_legal       access type is one of B/H/W/BU/HU
//   o_misaligned  legal type whose natural alignment is violated
module rv_dmem_align
    import rv_dmem_pkg::*;
(
    input  logic [1:0]      i_lane,
    input  logic [2:0]      i_bytectrl,
    input  logic [XLEN-1:0] i_wd,
    input  logic [XLEN-1:0] i_rword,
    output logic [3:0]      o_wmask,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rd,
    output logic            o_legal,
    output logic            o_misaligned
);

    logic [XLEN-1:0] shifted;

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        o_wmask      = 4'b0000;
        o_wdata      = '0;
        o_rd         = '0;
        o_misaligned = 1'b0;
        o_legal      = bc_legal(i_bytectrl);
        shifted      = i_rword >> {i_lane, 3'b000};

        case (i_bytectrl)
            BC_B, BC_BU: begin
                o_wmask = 4'b0001 << i_lane;
                o_wdata = {4{i_wd[7:0]}};
                o_rd    = (i_bytectrl == BC_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                               : {24'b0, shifted[7:0]};
            end
            BC_H, BC_HU: begin
                // Misaligned halves are discarded by the caller, so the lane
                // choice only needs to be right when a[0] == 0.
                o_misaligned = i_lane[0];
                o_wmask      = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wd[15:0]}};
                o_rd         = (i_bytectrl == BC_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                                    : {16'b0, shifted[15:0]};
            end
            BC_W: begin
                o_misaligned = (i_lane != 2'b00);
                o_wmask      = 4'b1111;
                o_wdata      = i_wd;
                o_rd         = i_rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_dmem.sv
// rv_dmem: data memory downstream of the core's MEM stage.
//   i_dmem_clk       clock
//   i_dmem_rstn      asynchronous active-low reset
//   i_dmem_a         byte address
//   i_dmem_wd        right-aligned store data
//   i_dmem_we        store enable
//   i_dmem_bytectrl  access type (func3 encoding)
//   o_dmem_rd        combinational load data
//   o_dmem_halt      sticky halt request (TOHOST written with bit 0 set)
//   o_dmem_tohost    last value written to TOHOST
//   o_dmem_status    sticky errors: [0] misaligned, [1] out-of-range / illegal type
// RAM occupies [0, 4*DEPTH_WORDS); the MMIO window is the 16 bytes at MMIO_BASE
// holding MTIME_LO, MTIME_HI, TOHOST and STATUS (write-1-to-clear).
module rv_dmem
    import rv_dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic            i_dmem_clk,
    input  logic            i_dmem_rstn,
    input  logic [XLEN-1:0] i_dmem_a,
    input  logic [XLEN-1:0] i_dmem_wd,
    input  logic            i_dmem_we,
    input  logic [2:0]      i_dmem_bytectrl,
    output logic [XLEN-1:0] o_dmem_rd,
    output logic            o_dmem_halt,
    output logic [XLEN-1:0] o_dmem_tohost,
    output logic [1:0]      o_dmem_status
);

    localparam int AW = $clog2(4 * DEPTH_WORDS);
    localparam int IW = AW - 2;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    logic [63:0]     cnt_q,    cnt_d;
    logic [XLEN-1:0] tohost_q, tohost_d;
    logic            halt_q,   halt_d;
    logic [1:0]      status_q, status_d;

    logic [IW-1:0]   idx;
    logic            is_ram, is_mmio;
    logic [3:0]      wmask;
    logic [XLEN-1:0] wdata, ram_rd;
    logic            legal, al_misaligned;
    logic            misaligned, illegal, fault;
    logic            ram_we, mmio_we;
    logic [1:0]      set_bits, clr_bits;
    mmio_reg_e       mmio_reg;

    assign idx      = i_dmem_a[AW-1:2];
    assign is_ram   = (i_dmem_a[31:AW] == '0);
    assign is_mmio  = (i_dmem_a[31:4] == MMIO_BASE[31:4]);
    assign mmio_reg = mmio_reg_e'(i_dmem_a[3:2]);

    rv_dmem_align u_align (
        .i_lane       (i_dmem_a[1:0]),
        .i_bytectrl   (i_dmem_bytectrl),
        .i_wd         (i_dmem_wd),
        .i_rword      (mem_q[idx]),
        .o_wmask      (wmask),
        .o_wdata      (wdata),
        .o_rd         (ram_rd),
        .o_legal      (legal),
        .o_misaligned (al_misaligned)
    );

    // MMIO only takes word accesses; a sub-word type there counts as misaligned.
    // Misaligned wins over out-of-range, so an unaligned access to an unmapped
    // address reports only status[0].
    always_comb begin
        misaligned = al_misaligned | (is_mmio & legal & (i_dmem_bytectrl != BC_W));
        illegal    = ~legal | (~is_ram & ~is_mmio);
        fault      = misaligned | illegal;
        ram_we     = i_dmem_we & is_ram  & ~fault;
        mmio_we    = i_dmem_we & is_mmio & ~fault;
    end

    // Load path: faulting accesses read as zero.
    always_comb begin
        o_dmem_rd = '0;
        if (!fault) begin
            if (is_ram) begin
                o_dmem_rd = ram_rd;
            end else begin
                case (mmio_reg)
                    MMIO_MTIME_LO: o_dmem_rd = cnt_q[31:0];
                    MMIO_MTIME_HI: o_dmem_rd = cnt_q[63:32];
                    MMIO_TOHOST:   o_dmem_rd = tohost_q;
                    MMIO_STATUS:   o_dmem_rd = {30'b0, status_q};
                endcase
            end
        end
    end

    // Next-state for the MMIO registers and counter. Only stores flag errors;
    // a newly raised error beats a same-cycle write-1-to-clear of that bit.
    always_comb begin
        cnt_d    = halt_q ? cnt_q : cnt_q + 64'd1;
        tohost_d = tohost_q;
        halt_d   = halt_q;
        clr_bits = 2'b00;

        set_bits[ST_MISALIGN] = i_dmem_we & misaligned;
        set_bits[ST_ILLEGAL]  = i_dmem_we & illegal & ~misaligned;

        if (mmio_we && mmio_reg == MMIO_TOHOST) begin
            tohost_d = i_dmem_wd;
            halt_d   = halt_q | i_dmem_wd[0];
        end
        if (mmio_we && mmio_reg == MMIO_STATUS) begin
            clr_bits = i_dmem_wd[1:0];
        end
        status_d = (status_q & ~clr_bits) | set_bits;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_dmem_clk or negedge i_dmem_rstn) begin
        if (!i_dmem_rstn) begin
            cnt_q    <= '0;
            tohost_q <= '0;
            halt_q   <= 1'b0;
            status_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            tohost_q <= tohost_d;
            halt_q   <= halt_d;
            status_q <= status_d;
        end
    end

    // NOTE: RAM contents are deliberately never cleared; reset only blocks writes
    // so a store caught by reset is dropped.
    always_ff @(posedge i_dmem_clk or negedge i_dmem_rstn) begin
        if (!i_dmem_rstn) begin
        end else if (ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (wmask[l]) mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

    assign o_dmem_halt   = halt_q;
    assign o_dmem_tohost = tohost_q;
    assign o_dmem_status = status_q;

endmodule

// File: tb/tb_rv_dmem.sv
// tb_rv_dmem: directed plus randomized checks of rv_dmem against a byte-array
// reference model of the memory map.
module tb_rv_dmem;

    localparam int          DEPTH     = 1024;
    localparam int          RAM_BYTES = 4 * DEPTH;
    localparam logic [31:0] MB        = 32'hFFFF_0000;
    localparam logic [2:0]  B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] a = '0, wd = '0;
    logic        we = 1'b0;
    logic [2:0]  bc = W;
    logic [31:0] rd, tohost;
    logic        halt;
    logic [1:0]  status;

    always #5 clk = ~clk;

    rv_dmem #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
        .i_dmem_clk      (clk),
        .i_dmem_rstn     (rstn),
        .i_dmem_a        (a),
        .i_dmem_wd       (wd),
        .i_dmem_we       (we),
        .i_dmem_bytectrl (bc),
        .o_dmem_rd       (rd),
        .o_dmem_halt     (halt),
        .o_dmem_tohost   (tohost),
        .o_dmem_status   (status)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [7:0]  m_mem [RAM_BYTES];
    logic [63:0] m_cnt = '0;
    logic [31:0] m_tohost = '0;
    logic        m_halt = 1'b0;
    logic [1:0]  m_status = '0;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_mmio(input logic [31:0] addr);
        return addr[31:4] == MB[31:4];
    endfunction

    function automatic int acc_size(input logic [2:0] t);
        return 1 << t[1:0];
    endfunction

    // 0 = ok, 1 = misaligned, 2 = out-of-range / illegal type
    function automatic int fault_kind(input logic [31:0] addr, input logic [2:0] t);
        int sz;
        if (!(t inside {B, H, W, BU, HU})) return 2;
        sz = acc_size(t);
        if (is_mmio(addr)) return (sz != 4 || addr[1:0] != 2'b00) ? 1 : 0;
        if ((addr % sz) != 0) return 1;
        if (addr < RAM_BYTES) return 0;
        return 2;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] t);
        logic [31:0] v;
        int sz;
        if (fault_kind(addr, t) != 0) return 32'h0;
        if (is_mmio(addr)) begin
            case (addr[3:2])
                2'd0:    return m_cnt[31:0];
                2'd1:    return m_cnt[63:32];
                2'd2:    return m_tohost;
                default: return {30'b0, m_status};
            endcase
        end
        sz = acc_size(t);
        v  = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(m_mem[addr + i]) << (8 * i));
        if (sz < 4 && !t[2] && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] t);
        int k;
        k = fault_kind(addr, t);
        if (k == 1) m_status[0] = 1'b1;
        else if (k == 2) m_status[1] = 1'b1;
        else if (is_mmio(addr)) begin
            if (addr[3:2] == 2'd2) begin
                m_tohost = data;
                m_halt   = m_halt | data[0];
            end else if (addr[3:2] == 2'd3) begin
                m_status = m_status & ~data[1:0];
            end
        end else begin
            for (int i = 0; i < acc_size(t); i++) m_mem[addr + i] = data[8*i +: 8];
        end
    endtask

    // One bus cycle: drive after a falling edge, check outputs mid-cycle,
    // then advance the model across the rising edge.
    task automatic bus(input logic we_i, input logic [31:0] a_i, input logic [31:0] wd_i,
                       input logic [2:0] bc_i);
        logic h;
        we = we_i; a = a_i; wd = wd_i; bc = bc_i;
        #1;
        last_rd = rd;
        check($sformatf("rd a=%h bc=%0d", a_i, bc_i), rd, model_load(a_i, bc_i));
        check("status", status, m_status);
        check("halt", halt, m_halt);
        check("tohost", tohost, m_tohost);
        @(posedge clk);
        h = m_halt;
        if (we_i) model_store(a_i, wd_i, bc_i);
        m_cnt = h ? m_cnt : m_cnt + 64'd1;
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] frozen, addr, data;
        logic [2:0]  t;
        int          r;

        // Reset state
        a = MB; bc = W;
        repeat (3) @(negedge clk);
        #1;
        check("rst halt", halt, 1'b0);
        check("rst tohost", tohost, 32'h0);
        check("rst status", status, 2'b00);
        check("rst mtime", rd, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        m_cnt = '0;

        // Counter after 10 cycles
        repeat (10) bus(1'b0, MB, 32'h0, W);
        bus(1'b0, MB, 32'h0, W);
        check("mtime10", last_rd, 32'd10);

        // Initialise the RAM region the rest of the run touches
        for (int i = 0; i < 64; i++) bus(1'b1, 32'(i * 4), $urandom, W);
        bus(1'b1, RAM_BYTES - 4, $urandom, W);

        // Sub-word loads
        bus(1'b1, 32'h10, 32'h8899AABB, W);
        bus(1'b0, 32'h13, 0, B);  check("lb13",  last_rd, 32'hFFFFFF88);
        bus(1'b0, 32'h13, 0, BU); check("lbu13", last_rd, 32'h00000088);
        bus(1'b0, 32'h10, 0, H);  check("lh10",  last_rd, 32'hFFFFAABB);
        bus(1'b0, 32'h12, 0, HU); check("lhu12", last_rd, 32'h00008899);

        // Sub-word stores preserve untouched lanes
        bus(1'b1, 32'h20, 32'h11223344, W);
        bus(1'b1, 32'h21, 32'h0000005A, B);
        bus(1'b0, 32'h20, 0, W); check("sb21", last_rd, 32'h11225A44);
        bus(1'b1, 32'h22, 32'h0000BEEF, H);
        bus(1'b0, 32'h20, 0, W); check("sh22", last_rd, 32'hBEEF5A44);

        // Misaligned store, W1C clear, misaligned store aimed at STATUS
        bus(1'b1, 32'h4, 32'hCAFEF00D, W);
        bus(1'b1, 32'h6, 32'hDEADDEAD, W);
        bus(1'b0, 32'h4, 0, W); check("mis ram", last_rd, 32'hCAFEF00D);
        check("mis status", status, 2'b01);
        bus(1'b1, MB + 32'hC, 32'h1, W);
        bus(1'b0, MB + 32'hC, 0, W); check("w1c", status, 2'b00);
        bus(1'b1, 32'h6, 32'h0, W);
        bus(1'b1, MB + 32'hD, 32'h1, W);
        bus(1'b0, MB + 32'hC, 0, W); check("set wins", status, 2'b01);
        bus(1'b1, MB + 32'hC, 32'h3, W);

        // RAM top boundary and unmapped space
        bus(1'b1, RAM_BYTES - 4, 32'h0BADF00D, W);
        bus(1'b0, RAM_BYTES - 4, 0, W); check("top word", last_rd, 32'h0BADF00D);
        bus(1'b1, RAM_BYTES, 32'h1, W);
        bus(1'b0, RAM_BYTES, 0, W); check("past top rd", last_rd, 32'h0);
        check("past top status", status, 2'b10);
        bus(1'b1, MB + 32'hC, 32'h3, W);
        bus(1'b1, 32'h0001_0000, 32'h1234, W);
        bus(1'b0, 32'h0001_0000, 0, W); check("unmapped rd", last_rd, 32'h0);
        check("unmapped status", status, 2'b10);
        bus(1'b1, MB + 32'hC, 32'h3, W);

        // Counter wrap
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        bus(1'b0, MB + 32'h4, 0, W); check("pre-wrap hi", last_rd, 32'hFFFFFFFF);
        bus(1'b0, MB + 32'h4, 0, W); check("wrap hi", last_rd, 32'h0);
        bus(1'b0, MB, 0, W);         check("wrap lo", last_rd, 32'h1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 7);
            if (r <= 4)      addr = $urandom_range(0, 255);
            else if (r == 5) addr = RAM_BYTES - 4 + $urandom_range(0, 7);
            else if (r == 6) addr = MB + $urandom_range(0, 15);
            else             addr = 32'h0001_0000 | $urandom;
            t    = 3'($urandom_range(0, 7));
            data = $urandom;
            if (is_mmio(addr)) data[0] = 1'b0;  // keep the counter running
            bus(1'($urandom_range(0, 1)), addr, data, t);
        end

        // Halt freezes the counter; later TOHOST writes still land
        bus(1'b1, MB + 32'h8, 32'h1, W);
        check("halt set", halt, 1'b1);
        check("tohost 1", tohost, 32'h1);
        bus(1'b0, MB, 0, W);
        frozen = last_rd;
        for (int i = 0; i < 5; i++) begin
            bus(1'b0, MB, 0, W);
            check("frozen", last_rd, frozen);
        end
        bus(1'b1, MB + 32'h8, 32'h4, W);
        bus(1'b0, MB + 32'h8, 0, W);
        check("tohost 4", tohost, 32'h4);
        check("halt stays", halt, 1'b1);

        // Reset during a store
        bus(1'b1, 32'h30, 32'h12345678, W);
        bus(1'b1, 32'h6, 32'h0, W);
        we = 1'b1; a = 32'h30; wd = 32'hFFFFFFFF; bc = W;
        #2;
        rstn = 1'b0;
        #1;
        check("arst halt", halt, 1'b0);
        check("arst tohost", tohost, 32'h0);
        check("arst status", status, 2'b00);
        a = MB;
        #1;
        check("arst mtime", rd, 32'h0);
        a = 32'h30;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        rstn = 1'b1;
        m_cnt = '0; m_halt = 1'b0; m_tohost = '0; m_status = '0;
        bus(1'b0, 32'h30, 0, W); check("store lost", last_rd, 32'h12345678);
        bus(1'b0, MB, 0, W);     check("cnt restart", last_rd, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
